// File: rtl/djikstra_pkg.sv
// Shared types and constants for the shortest-path job controller.
// Edge word layout: [3:0] parent, [7:4] child, [11:8] weight.
package djikstra_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    localparam int EDGE_W     = 12;
    localparam int PARENT_LSB = 0;
    localparam int CHILD_LSB  = 4;
    localparam int WEIGHT_LSB = 8;
    localparam int NODE_MAX   = 15;
    localparam int N_W        = 4;
    localparam int E_W        = 8;
    localparam int SP_W       = 256;

    function automatic logic [EDGE_W-1:0] mk_edge(input logic [3:0] parent,
                                                  input logic [3:0] child,
                                                  input logic [3:0] weight);
        logic [EDGE_W-1:0] w;
        w = '0;
        w[PARENT_LSB +: 4] = parent;
        w[CHILD_LSB  +: 4] = child;
        w[WEIGHT_LSB +: 4] = weight;
        return w;
    endfunction

endpackage

// File: rtl/sssp_edge_buf.sv
// Edge table: one write port addressed by the load index, whole table
// exported in parallel as the core's data bus. Contents survive reset.
module sssp_edge_buf
    import djikstra_pkg::*;
#(
    parameter int MAX_EDGES = 256
) (
    input  logic                               clk,
    input  logic                               we,
    input  logic [E_W-1:0]                     idx,
    input  logic [EDGE_W-1:0]                  data,
    output logic [MAX_EDGES-1:0][EDGE_W-1:0]   core_data
);

    genvar gi;
    generate
        for (gi = 0; gi < MAX_EDGES; gi++) begin : g_ent
            logic [EDGE_W-1:0] ent_reg;

            always_ff @(posedge clk) begin
                if (we && idx == E_W'(gi)) begin
                    ent_reg <= data;
                end
            end

            assign core_data[gi] = ent_reg;
        end
    endgenerate

endmodule

// File: rtl/sssp_job_ctrl.sv
// Job controller for the shortest-path core: takes a job header and edges,
// launches the core, waits with a timeout, then streams per-node distances out.
module sssp_job_ctrl
    import djikstra_pkg::*;
#(
    parameter int MAX_EDGES = 256,
    parameter int DIST_W    = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               job_start,
    input  logic [N_W-1:0]                     job_n,
    input  logic [E_W-1:0]                     job_e,
    input  logic                               edge_valid,
    input  logic [EDGE_W-1:0]                  edge_data,
    output logic                               edge_ready,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [N_W-1:0]                     res_node,
    output logic [DIST_W-1:0]                  res_dist,
    output logic                               res_sat,
    output logic                               res_last,
    output logic                               busy,
    output logic                               done,
    output logic                               err_cfg,
    output logic                               err_timeout,
    output logic [N_W-1:0]                     core_n,
    output logic [E_W-1:0]                     core_e,
    output logic [MAX_EDGES-1:0][EDGE_W-1:0]   core_data,
    output logic                               core_valid,
    output logic                               core_ready,
    output logic                               core_hold,
    input  logic [NODE_MAX:0][SP_W-1:0]        core_sp,
    input  logic                               core_valid_out
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t               state_reg, state_next;
    logic [N_W-1:0]       core_n_reg;
    logic [E_W-1:0]       core_e_reg;
    logic [E_W-1:0]       idx_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic [N_W-1:0]       res_idx_reg;
    logic [DIST_W-1:0]    dist_reg [NODE_MAX+1];
    logic [NODE_MAX:0]    sat_reg;
    logic                 err_cfg_reg;
    logic                 err_timeout_reg;
    logic                 done_reg;

    logic [DIST_W-1:0]    sp_dist [NODE_MAX+1];
    logic [NODE_MAX:0]    sp_sat;

    logic edge_we;
    logic capture;
    logic expire;
    logic res_fire;
    logic last_word;

    // Anything above the reported width (including the core's "unreachable"
    // encoding) collapses to all-ones with the saturation flag.
    genvar gi;
    generate
        for (gi = 0; gi <= NODE_MAX; gi++) begin : g_sat
            assign sp_sat[gi]  = |core_sp[gi][SP_W-1:DIST_W];
            assign sp_dist[gi] = sp_sat[gi] ? '1 : core_sp[gi][DIST_W-1:0];
        end
    endgenerate

    sssp_edge_buf #(
        .MAX_EDGES (MAX_EDGES)
    ) u_edge_buf (
        .clk       (clk),
        .we        (edge_we),
        .idx       (idx_reg),
        .data      (edge_data),
        .core_data (core_data)
    );

    always_comb begin
        state_next = state_reg;
        edge_ready = 1'b0;
        core_valid = 1'b0;
        core_ready = 1'b0;
        core_hold  = 1'b0;
        res_valid  = 1'b0;
        res_last   = 1'b0;
        edge_we    = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        res_fire   = 1'b0;
        last_word  = (res_idx_reg == core_n_reg - N_W'(1));

        case (state_reg)
            ST_IDLE: begin
                if (job_start && job_n != '0) begin
                    state_next = (job_e == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                edge_ready = 1'b1;
                edge_we    = edge_valid;
                if (edge_valid && idx_reg == core_e_reg - E_W'(1)) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                core_valid = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                core_ready = 1'b1;
                // A result arriving on the last allowed cycle still wins.
                if (core_valid_out) begin
                    capture    = 1'b1;
                    state_next = ST_DRAIN;
                end else if (tmo_reg == TMO_W'(TIMEOUT - 1)) begin
                    expire     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                core_hold = 1'b1;
                res_valid = 1'b1;
                res_last  = last_word;
                res_fire  = res_ready;
                if (res_ready && last_word) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            core_n_reg      <= '0;
            core_e_reg      <= '0;
            idx_reg         <= '0;
            tmo_reg         <= '0;
            res_idx_reg     <= '0;
            sat_reg         <= '0;
            err_cfg_reg     <= 1'b0;
            err_timeout_reg <= 1'b0;
            done_reg        <= 1'b0;
            for (int i = 0; i <= NODE_MAX; i++) begin
                dist_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            done_reg  <= res_fire && last_word;

            if (state_reg == ST_IDLE && job_start) begin
                if (job_n == '0) begin
                    err_cfg_reg <= 1'b1;
                end else begin
                    core_n_reg      <= job_n;
                    core_e_reg      <= job_e;
                    idx_reg         <= '0;
                    err_cfg_reg     <= 1'b0;
                    err_timeout_reg <= 1'b0;
                end
            end

            if (edge_we) begin
                idx_reg <= idx_reg + E_W'(1);
            end

            if (state_reg == ST_RUN) begin
                tmo_reg <= '0;
            end else if (state_reg == ST_WAIT) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end

            if (expire) begin
                err_timeout_reg <= 1'b1;
            end

            if (capture) begin
                res_idx_reg <= '0;
                for (int i = 0; i <= NODE_MAX; i++) begin
                    if (N_W'(i) < core_n_reg) begin
                        dist_reg[i] <= sp_dist[i];
                        sat_reg[i]  <= sp_sat[i];
                    end
                end
            end else if (res_fire && !last_word) begin
                res_idx_reg <= res_idx_reg + N_W'(1);
            end
        end
    end

    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
    assign err_cfg     = err_cfg_reg;
    assign err_timeout = err_timeout_reg;
    assign core_n      = core_n_reg;
    assign core_e      = core_e_reg;
    assign res_node    = res_idx_reg;
    assign res_dist    = dist_reg[res_idx_reg];
    assign res_sat     = sat_reg[res_idx_reg];

endmodule

// File: tb/tb_sssp_job_ctrl.sv
// Randomized bench for sssp_job_ctrl: drives jobs, plays the core, and checks
// the result stream against distances computed directly from the core values.
module tb_sssp_job_ctrl;
    import djikstra_pkg::*;

    localparam int MAX_EDGES = 256;
    localparam int DIST_W    = 16;
    localparam int TIMEOUT   = 8;

    logic                              clk = 1'b0;
    logic                              reset;
    logic                              job_start;
    logic [3:0]                        job_n;
    logic [7:0]                        job_e;
    logic                              edge_valid;
    logic [11:0]                       edge_data;
    logic                              edge_ready;
    logic                              res_valid;
    logic                              res_ready;
    logic [3:0]                        res_node;
    logic [DIST_W-1:0]                 res_dist;
    logic                              res_sat;
    logic                              res_last;
    logic                              busy;
    logic                              done;
    logic                              err_cfg;
    logic                              err_timeout;
    logic [3:0]                        core_n;
    logic [7:0]                        core_e;
    logic [MAX_EDGES-1:0][11:0]        core_data;
    logic                              core_valid;
    logic                              core_ready;
    logic                              core_hold;
    logic [15:0][255:0]                core_sp;
    logic                              core_valid_out;

    int checks = 0;
    int errors = 0;

    logic [11:0]  edges  [256];
    logic [255:0] sp_val [16];

    sssp_job_ctrl #(
        .MAX_EDGES (MAX_EDGES),
        .DIST_W    (DIST_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .job_start      (job_start),
        .job_n          (job_n),
        .job_e          (job_e),
        .edge_valid     (edge_valid),
        .edge_data      (edge_data),
        .edge_ready     (edge_ready),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_node       (res_node),
        .res_dist       (res_dist),
        .res_sat        (res_sat),
        .res_last       (res_last),
        .busy           (busy),
        .done           (done),
        .err_cfg        (err_cfg),
        .err_timeout    (err_timeout),
        .core_n         (core_n),
        .core_e         (core_e),
        .core_data      (core_data),
        .core_valid     (core_valid),
        .core_ready     (core_ready),
        .core_hold      (core_hold),
        .core_sp        (core_sp),
        .core_valid_out (core_valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_busy"},        busy,        0);
        check_eq({tag, "_done"},        done,        0);
        check_eq({tag, "_res_valid"},   res_valid,   0);
        check_eq({tag, "_edge_ready"},  edge_ready,  0);
        check_eq({tag, "_core_valid"},  core_valid,  0);
        check_eq({tag, "_core_ready"},  core_ready,  0);
        check_eq({tag, "_core_hold"},   core_hold,   0);
        check_eq({tag, "_err_cfg"},     err_cfg,     0);
        check_eq({tag, "_err_timeout"}, err_timeout, 0);
        check_eq({tag, "_core_n"},      core_n,      0);
        check_eq({tag, "_core_e"},      core_e,      0);
        check_eq({tag, "_res_dist"},    res_dist,    0);
        check_eq({tag, "_res_last"},    res_last,    0);
    endtask

    function automatic logic [255:0] rand_sp();
        logic [255:0] v;
        v = '0;
        case ($urandom_range(0, 5))
            0, 1: v[15:0] = 16'($urandom);
            2:    v = 256'h0FFFF;
            3:    v = 256'h10000;
            4:    v[20] = 1'b1;
            default: begin
                v[15:0] = 16'($urandom);
                v[255]  = 1'b1;
            end
        endcase
        return v;
    endfunction

    // d < 0: the core never answers. bp: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic run_job(input int n, input int e, input int d, input int bp, input bit b2b);
        int hs, guard, w, got, k;
        bit rdy_pat [4];
        logic        exp_sat;
        logic [15:0] exp_dist;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        $display("job n=%0d e=%0d delay=%0d bp=%0d b2b=%0d", n, e, d, bp, b2b);

        @(negedge clk);
        job_start = 1'b1;
        job_n     = 4'(n);
        job_e     = 8'(e);
        @(negedge clk);
        job_start = 1'b0;
        check_eq("start_busy", busy, 1);
        check_eq("start_err_cfg", err_cfg, 0);
        check_eq("start_err_timeout", err_timeout, 0);

        if (e > 0) begin
            check_eq("load_edge_ready", edge_ready, 1);
            hs = 0;
            guard = 0;
            while (hs < e && guard < 2000) begin
                edge_valid = b2b ? 1'b1 : ($urandom_range(0, 2) != 0);
                edge_data  = edges[hs];
                // A stray request outside IDLE must be ignored without raising err_cfg.
                job_start  = (guard == 1);
                job_n      = 4'd0;
                if (edge_valid && edge_ready) hs++;
                @(negedge clk);
                guard++;
            end
            edge_valid = 1'b0;
            job_start  = 1'b0;
            check_eq("load_count", hs, e);
            if (b2b) check_eq("load_cycles", guard, e);
        end

        check_eq("run_core_valid", core_valid, 1);
        check_eq("run_core_n", core_n, n);
        check_eq("run_core_e", core_e, e);
        check_eq("run_err_cfg", err_cfg, 0);
        for (int i = 0; i < e; i++) check_eq("core_data", core_data[i], edges[i]);

        @(negedge clk);
        check_eq("wait_core_valid_off", core_valid, 0);
        check_eq("wait_core_ready", core_ready, 1);

        if (d < 0) begin
            w = 0;
            while (core_ready && w < 40) begin
                check_eq("tmo_no_res", res_valid, 0);
                w++;
                @(negedge clk);
            end
            check_eq("tmo_wait_cycles", w, TIMEOUT);
            check_eq("tmo_err", err_timeout, 1);
            check_eq("tmo_busy", busy, 0);
            check_eq("tmo_res_valid", res_valid, 0);
            @(negedge clk);
            check_eq("tmo_no_done", done, 0);
            return;
        end

        repeat (d) @(negedge clk);
        check_eq("core_ready_at_result", core_ready, 1);
        for (int i = 0; i < 16; i++) core_sp[i] = sp_val[i];
        core_valid_out = 1'b1;
        @(negedge clk);
        core_valid_out = 1'b0;
        for (int i = 0; i < 16; i++) core_sp[i] = '0;
        check_eq("first_res_valid", res_valid, 1);
        check_eq("drain_core_hold", core_hold, 1);
        check_eq("result_err_timeout", err_timeout, 0);

        got = 0;
        k = 0;
        guard = 0;
        while (got < n && guard < 500) begin
            res_ready = (bp == 0) ? 1'b1 : (bp == 1) ? rdy_pat[k % 4] : 1'($urandom_range(0, 1));
            k++;
            if (!res_valid) begin
                check_eq("drain_res_valid", res_valid, 1);
                break;
            end
            exp_sat  = (sp_val[got] >> DIST_W) != 0;
            exp_dist = exp_sat ? 16'hFFFF : sp_val[got][15:0];
            check_eq("res_node", res_node, got);
            check_eq("res_dist", res_dist, exp_dist);
            check_eq("res_sat",  res_sat,  exp_sat);
            check_eq("res_last", res_last, (got == n - 1));
            if (res_ready) got++;
            @(negedge clk);
            guard++;
        end
        res_ready = 1'b0;
        check_eq("words_received", got, n);
        check_eq("done_pulse", done, 1);
        check_eq("end_busy", busy, 0);
        check_eq("end_res_valid", res_valid, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
    endtask

    task automatic random_job();
        int n, e;
        n = $urandom_range(1, 15);
        e = $urandom_range(0, 24);
        for (int i = 0; i < e; i++)
            edges[i] = mk_edge(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 16; i++) sp_val[i] = rand_sp();
        run_job(n, e, $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        reset          = 1'b0;
        job_start      = 1'b0;
        job_n          = '0;
        job_e          = '0;
        edge_valid     = 1'b0;
        edge_data      = '0;
        res_ready      = 1'b0;
        core_valid_out = 1'b0;
        for (int i = 0; i < 16; i++) core_sp[i] = '0;

        repeat (3) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;

        // Basic job: 0->1 w2, 1->2 w3, 0->3 w9, distances {0,2,5,9}.
        edges[0] = mk_edge(4'd0, 4'd1, 4'd2);
        edges[1] = mk_edge(4'd1, 4'd2, 4'd3);
        edges[2] = mk_edge(4'd0, 4'd3, 4'd9);
        for (int i = 0; i < 16; i++) sp_val[i] = rand_sp();
        sp_val[0] = 256'd0;
        sp_val[1] = 256'd2;
        sp_val[2] = 256'd5;
        sp_val[3] = 256'd9;
        run_job(4, 3, 0, 0, 1'b1);
        run_job(4, 3, 2, 1, 1'b1);

        // Zero edges with a saturated distance.
        sp_val[0] = 256'd0;
        sp_val[1] = 256'd1 << 20;
        run_job(2, 0, 1, 0, 1'b1);

        // Timeout, then a result on the very last allowed cycle.
        run_job(3, 2, -1, 0, 1'b1);
        for (int i = 0; i < 16; i++) sp_val[i] = rand_sp();
        run_job(2, 1, TIMEOUT - 1, 0, 1'b1);

        for (int j = 0; j < 10; j++) random_job();

        // Timeout leaves err_timeout set; a bad config adds err_cfg.
        run_job(1, 1, -1, 0, 1'b1);
        @(negedge clk);
        job_start = 1'b1;
        job_n     = 4'd0;
        job_e     = 8'd3;
        @(negedge clk);
        job_start = 1'b0;
        $display("job bad config n=0");
        check_eq("badcfg_err_cfg", err_cfg, 1);
        check_eq("badcfg_busy", busy, 0);
        check_eq("badcfg_err_timeout_kept", err_timeout, 1);

        // Reset part-way through loading 5 edges.
        edges[0] = mk_edge(4'd2, 4'd5, 4'd7);
        edges[1] = mk_edge(4'd5, 4'd1, 4'd3);
        @(negedge clk);
        job_start = 1'b1;
        job_n     = 4'd5;
        job_e     = 8'd5;
        @(negedge clk);
        job_start  = 1'b0;
        edge_valid = 1'b1;
        edge_data  = edges[0];
        @(negedge clk);
        edge_data  = edges[1];
        @(negedge clk);
        edge_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        $display("job reset after 2 of 5 edges");
        check_cleared("midreset");
        check_eq("table_kept0", core_data[0], edges[0]);
        check_eq("table_kept1", core_data[1], edges[1]);
        reset = 1'b1;

        random_job();
        random_job();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
